// File: rtl/hs_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hs_rr_arbiter
// Description : Round-robin arbiter sharing one valid/ready slave port among
//               N valid/ready requesters, with a per-grant beat limit.
//               Define ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_rr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         s_valid,
  input  logic [N*DW-1:0]      s_data,
  output logic [N-1:0]         s_ready,
  output logic                 m_valid,
  output logic [DW-1:0]        m_data,
  input  logic                 m_ready,
  output logic [$clog2(N)-1:0] m_src,
  output logic                 busy
);

  localparam int c_SW = $clog2(N);
  localparam int c_BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_GRANT = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_next_state;
  logic [c_SW-1:0] r_owner;
  logic [c_BW-1:0] r_beat_cnt;
  logic [c_SW-1:0] w_start;
  logic [c_SW-1:0] w_pick;
  logic [c_SW:0]   w_idx;
  logic            w_any;
  logic            w_own_valid;
  logic            w_hs;
  logic            w_last_beat;
  logic            w_release;
  logic [DW-1:0]   w_data [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_data[gi] = s_data[gi*DW +: DW];
  end

`ifdef ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [c_SW-1:0] r_last;

  assign w_start = (r_last == c_SW'(N - 1)) ? '0 : r_last + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= c_SW'(N - 1);
    end else if (r_state == c_GRANT && w_release) begin
      r_last <= r_owner;
    end
  end
`endif

  assign w_any       = |s_valid;
  assign w_own_valid = s_valid[r_owner];
  assign w_hs        = (r_state == c_GRANT) && w_own_valid && m_ready;
  assign w_last_beat = (r_beat_cnt == c_BW'(MAX_BURST - 1));
  assign w_release   = (w_hs && w_last_beat) || !w_own_valid;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = {1'b0, w_start} + (c_SW + 1)'(i);
      if (w_idx >= (c_SW + 1)'(N)) begin
        w_idx = w_idx - (c_SW + 1)'(N);
      end
      if (s_valid[w_idx[c_SW-1:0]]) begin
        w_pick = w_idx[c_SW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == c_IDLE && w_any) begin
        r_owner    <= w_pick;
        r_beat_cnt <= '0;
      end else if (w_hs) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_any) w_next_state = c_GRANT;
      c_GRANT: if (w_release) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Gated by rst so a stale grant cannot complete a handshake in the reset cycle.
  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = '0;
    busy    = 1'b0;
    if (!rst && r_state == c_GRANT) begin
      m_valid          = w_own_valid;
      m_data           = w_own_valid ? w_data[r_owner] : '0;
      s_ready[r_owner] = m_ready;
      busy             = 1'b1;
      m_src            = r_owner;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_rr_arbiter
// Description : Directed vector bench for hs_rr_arbiter (N=4, MAX_BURST=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  s_valid;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]  s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [1:0]    m_src;
  logic          busy;

  hs_rr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .m_src   (m_src),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rst;
    logic [N-1:0]  sv;
    logic          mr;
    logic [N-1:0]  e_sready;
    logic          e_mvalid;
    logic [DW-1:0] e_mdata;
    logic [1:0]    e_src;
    logic          e_busy;
  } vec_t;

  logic [DW-1:0] dval [N];
  vec_t vq[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t v_idle(string nm, logic r, logic [N-1:0] sv, logic mr);
    vec_t v;
    v.name = nm; v.rst = r; v.sv = sv; v.mr = mr;
    v.e_sready = '0; v.e_mvalid = 1'b0; v.e_mdata = '0; v.e_src = '0; v.e_busy = 1'b0;
    return v;
  endfunction

  function automatic vec_t v_grant(string nm, logic [N-1:0] sv, logic mr, int own);
    vec_t v;
    v.name = nm; v.rst = 1'b0; v.sv = sv; v.mr = mr;
    v.e_sready      = '0;
    v.e_sready[own] = mr;
    v.e_mvalid      = sv[own];
    v.e_mdata       = sv[own] ? dval[own] : '0;
    v.e_src         = 2'(own);
    v.e_busy        = 1'b1;
    return v;
  endfunction

  task automatic step(input vec_t v);
    rst     = v.rst;
    s_valid = v.sv;
    m_ready = v.mr;
    @(negedge clk);
    n_checks++;
    if (s_ready === v.e_sready && m_valid === v.e_mvalid && m_data === v.e_mdata &&
        m_src === v.e_src && busy === v.e_busy) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got sready=%b mvalid=%b mdata=%h src=%0d busy=%b, expected sready=%b mvalid=%b mdata=%h src=%0d busy=%b",
               v.name, $time, s_ready, m_valid, m_data, m_src, busy,
               v.e_sready, v.e_mvalid, v.e_mdata, v.e_src, v.e_busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    dval[0] = 32'h1000_000A;
    dval[1] = 32'h2000_000B;
    dval[2] = 32'hA5A5_0001;
    dval[3] = 32'h4000_000D;
    s_data  = {dval[3], dval[2], dval[1], dval[0]};
    rst = 1'b1; s_valid = '0; m_ready = 1'b0;
    @(posedge clk);
    #1;

    vq.push_back(v_idle("rst0", 1'b1, 4'b0000, 1'b0));
    vq.push_back(v_idle("rst1", 1'b1, 4'b0000, 1'b0));
    vq.push_back(v_idle("idle", 1'b0, 4'b0000, 1'b1));
    vq.push_back(v_idle("single_arb", 1'b0, 4'b0100, 1'b1));
    vq.push_back(v_grant("single_b0", 4'b0100, 1'b1, 2));
    vq.push_back(v_grant("single_b1", 4'b0100, 1'b1, 2));
    vq.push_back(v_grant("single_drop", 4'b0000, 1'b1, 2));
    vq.push_back(v_idle("single_idle", 1'b0, 4'b0000, 1'b0));
    if (!FIXED) begin
      vq.push_back(v_idle("early_arb", 1'b0, 4'b1001, 1'b1));
      vq.push_back(v_grant("early_b0", 4'b1001, 1'b1, 3));
      vq.push_back(v_grant("early_b1", 4'b1001, 1'b1, 3));
      vq.push_back(v_grant("early_drop", 4'b0001, 1'b1, 3));
      vq.push_back(v_idle("early_idle", 1'b0, 4'b0001, 1'b1));
      vq.push_back(v_grant("wrap_g0", 4'b0001, 1'b1, 0));
      vq.push_back(v_grant("wrap_drop", 4'b0000, 1'b1, 0));
      vq.push_back(v_idle("wrap_idle", 1'b0, 4'b0000, 1'b0));
    end else begin
      vq.push_back(v_idle("fx_arb", 1'b0, 4'b1001, 1'b1));
      vq.push_back(v_grant("fx_g0", 4'b1001, 1'b1, 0));
      vq.push_back(v_grant("fx_drop0", 4'b1000, 1'b1, 0));
      vq.push_back(v_idle("fx_idle0", 1'b0, 4'b1000, 1'b1));
      vq.push_back(v_grant("fx_g3", 4'b1000, 1'b1, 3));
      vq.push_back(v_grant("fx_drop3", 4'b0000, 1'b1, 3));
      vq.push_back(v_idle("fx_idle3", 1'b0, 4'b0000, 1'b0));
    end
    for (int i = 0; i < vq.size(); i++) step(vq[i]);

    // All requesters active: four beats per grant, one idle cycle between grants.
    step(v_idle("fair_rst", 1'b1, 4'b0000, 1'b0));
    for (int c = 0; c < 25; c++) begin
      if (c % 5 == 0) step(v_idle("fair_idle", 1'b0, 4'b1111, 1'b1));
      else            step(v_grant("fair_grant", 4'b1111, 1'b1, FIXED ? 0 : (c / 5) % 4));
    end

    // Backpressure must neither advance the beat count nor release the grant.
    step(v_idle("bp_rst", 1'b1, 4'b0000, 1'b0));
    step(v_idle("bp_arb", 1'b0, 4'b0010, 1'b0));
    for (int c = 0; c < 10; c++) step(v_grant("bp_hold", 4'b0010, 1'b0, 1));
    for (int c = 0; c < MB; c++) step(v_grant("bp_beat", 4'b0010, 1'b1, 1));
    step(v_idle("bp_release", 1'b0, 4'b0010, 1'b1));
    step(v_grant("bp_regrant", 4'b0010, 1'b1, 1));

    // Reset during beat 2 of owner 1, then re-arbitrate from a clean state.
    step(v_idle("rst_mid", 1'b1, 4'b1010, 1'b1));
    step(v_idle("rst_after", 1'b0, 4'b1010, 1'b1));
    for (int c = 0; c < MB; c++) step(v_grant("rst_first", 4'b1010, 1'b1, 1));
    step(v_idle("rst_release", 1'b0, 4'b1010, 1'b1));
    step(v_grant("rst_next", 4'b1010, 1'b1, FIXED ? 1 : 3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hs_rr_arbiter.md
Name: hs_rr_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready downstream slave port between N valid/ready requesters.
- Sits between several master-side producers and a single handshake slave such as the team's registered-handshake slaves.
- Grants one requester at a time, passes its data and handshake through, and enforces a per-grant beat limit for fairness.

Parameters:
- N, 4, number of requesters (2..16)
- DW, 32, data width per requester
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration (>=1)

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- s_valid  input  N  per-requester valid
- s_data  input  N*DW  requester i data at [i*DW +: DW]
- s_ready  output  N  per-requester ready
- m_valid  output  1  downstream valid
- m_data  output  DW  downstream data
- m_ready  input  1  downstream ready
- m_src  output  clog2(N)  index of current owner, valid while busy=1
- busy  output  1  grant active

Behaviour:
- States: IDLE, GRANT. Registers: state, owner[clog2(N)-1:0], last[clog2(N)-1:0], beat_cnt[clog2(MAX_BURST+1)-1:0].
- Reset (rst=1 at posedge):
  - state=IDLE, owner=0, last=N-1 so the first search starts at requester 0, beat_cnt=0.
  - Outputs: s_ready=0, m_valid=0, m_data=0, m_src=0, busy=0.
  - Reset mid-transfer discards the grant immediately; no handshake completes in the reset cycle.
- IDLE:
  - Outputs are zero.
  - If any s_valid is set, search indices last+1, last+2, ... modulo N. The first set bit becomes owner. Then beat_cnt<=0, state<=GRANT.
  - Otherwise stay in IDLE.
  - Arbitration latency is 1 cycle: the earliest transfer is the cycle after s_valid is first seen.
- GRANT, combinational pass-through:
  - m_valid=s_valid[owner], m_data=s_data[owner].
  - s_ready[owner]=m_ready; all other s_ready bits are 0.
  - busy=1, m_src=owner.
- Handshake: a beat completes when s_valid[owner] & m_ready. On completion, beat_cnt<=beat_cnt+1.
- Release, GRANT->IDLE with last<=owner, when either:
  - (a) a beat completes and beat_cnt==MAX_BURST-1; or
  - (b) s_valid[owner]==0 in GRANT.
- Valid is never withdrawn before its handshake, so (b) occurs only after a completed beat. With (b), m_valid=0 for that cycle.
- Non-owner requesters with s_valid=1 hold their valid and data; they are never dropped, only delayed.
- Wrap-around: the search index wraps from N-1 to 0.
- With a single requester active, it is re-granted after each release. That costs 1 idle cycle per MAX_BURST beats.
- m_ready is allowed to be low indefinitely; the grant holds and beat_cnt does not advance.
- m_data is 0 when m_valid=0.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: the IDLE search always starts at index 0, so the lowest set index wins. MAX_BURST release still applies. last is unused.
- Undefined: round-robin as above.

Test Plan:
- Reset then idle: rst high 2 cycles, all s_valid=0 -> s_ready=0, m_valid=0, busy=0, m_data=0 every cycle.
- Single requester:
  - s_valid=4'b0100, s_data[2]=32'hA5A5_0001, m_ready=1.
  - Required: busy=1, m_src=2 one cycle later; m_valid=1, m_data=32'hA5A5_0001, s_ready=4'b0100 the same cycle.
- Round-robin fairness:
  - All four requesters hold valid continuously, m_ready=1, MAX_BURST=4.
  - Required: grants in order 0,1,2,3,0; exactly 4 beats each; 1 idle cycle between grants.
- Backpressure:
  - Owner 1 valid, m_ready=0 for 10 cycles, then 1.
  - Required: m_valid=1 and m_data stable throughout; s_ready[1]=0 until m_ready rises; beat_cnt unchanged; grant not released.
- Early release:
  - Owner 3 sends 2 beats then drops valid.
  - Required: IDLE next cycle, last=3; a pending requester 0 is granted next, since the search wraps 3->0.
- Reset mid-grant:
  - rst=1 during beat 2 of owner 1.
  - Required: next cycle busy=0, s_ready=0; the first grant after reset goes to the lowest pending index. Also run with ARB_FIXED_PRIO_EN: s_valid=4'b1010 always -> requester 1 always granted first.
